// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: multi-beat read/write bursts to the HPS/DDR3 port.
// Read beats land in a show-ahead FIFO; a read is only accepted when the FIFO can hold all of it.
module avalon_burst_master #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int BURST_W    = 7,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                main_clk,
  input  logic                main_reset_n,
  output logic                avm_m0_read,
  output logic                avm_m0_write,
  output logic [ADDR_W-1:0]   avm_m0_address,
  output logic [DATA_W-1:0]   avm_m0_writedata,
  output logic [DATA_W/8-1:0] avm_m0_byteenable,
  output logic [BURST_W-1:0]  avm_m0_burstcount,
  input  logic                avm_m0_waitrequest,
  input  logic [DATA_W-1:0]   avm_m0_readdata,
  input  logic                avm_m0_readdatavalid,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [BURST_W-1:0]  cmd_burstcount,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                write_complete,
  output logic                read_complete,
  output logic                cmd_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = (CNT_W > BURST_W) ? CNT_W : BURST_W;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic               write_complete_q, write_complete_d;
  logic               read_complete_q, read_complete_d;
  logic               cmd_error_q, cmd_error_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];

  logic               cmd_illegal;
  logic               cmd_fits;
  logic               cmd_fire;
  logic               wr_beat;
  logic               last_beat;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   free_slots;

  assign free_slots  = CNT_W'(FIFO_DEPTH) - count_q;
  assign cmd_illegal = (cmd_burstcount == '0) || (cmd_burstcount > BURST_W'(MAX_BURST));
  assign cmd_fits    = CMP_W'(free_slots) >= CMP_W'(cmd_burstcount);
  // Illegal counts bypass the reservation so an oversized read cannot wedge the port.
  assign cmd_ready   = main_reset_n && (state_q == IDLE) && (cmd_write || cmd_illegal || cmd_fits);
  assign cmd_fire    = cmd_valid && cmd_ready;

  assign avm_m0_write      = (state_q == WR_BURST) && wr_valid;
  assign avm_m0_read       = (state_q == RD_CMD);
  assign avm_m0_writedata  = avm_m0_write ? wr_data : '0;
  assign avm_m0_byteenable = (avm_m0_read || avm_m0_write) ? '1 : '0;
  assign avm_m0_address    = addr_q;
  assign avm_m0_burstcount = burst_q;
  assign wr_ready          = (state_q == WR_BURST) && !avm_m0_waitrequest;

  assign write_complete = write_complete_q;
  assign read_complete  = read_complete_q;
  assign cmd_error      = cmd_error_q;

  assign wr_beat   = avm_m0_write && !avm_m0_waitrequest;
  assign last_beat = (beat_q == burst_q - BURST_W'(1));
  assign push      = avm_m0_readdatavalid && ((state_q == RD_CMD) || (state_q == RD_DATA));
  assign rd_valid  = (count_q != '0);
  assign pop       = rd_valid && rd_ready;
  assign rd_data   = rd_valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    burst_d          = burst_q;
    beat_d           = beat_q;
    write_complete_d = 1'b0;
    read_complete_d  = 1'b0;
    cmd_error_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d  = cmd_address;
          burst_d = cmd_burstcount;
          beat_d  = '0;
          if (cmd_illegal) cmd_error_d = 1'b1;
          else             state_d = cmd_write ? WR_BURST : RD_CMD;
        end
      end
      WR_BURST: begin
        if (wr_beat) begin
          beat_d = beat_q + BURST_W'(1);
          if (last_beat) begin
            state_d          = IDLE;
            write_complete_d = 1'b1;
          end
        end
      end
      RD_CMD: begin
        if (push) beat_d = beat_q + BURST_W'(1);
        if (!avm_m0_waitrequest) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (push) begin
          beat_d = beat_q + BURST_W'(1);
          if (last_beat) begin
            state_d         = IDLE;
            read_complete_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge main_clk or negedge main_reset_n) begin
    if (!main_reset_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      burst_q          <= '0;
      beat_q           <= '0;
      write_complete_q <= 1'b0;
      read_complete_q  <= 1'b0;
      cmd_error_q      <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      burst_q          <= burst_d;
      beat_q           <= beat_d;
      write_complete_q <= write_complete_d;
      read_complete_q  <= read_complete_d;
      cmd_error_q      <= cmd_error_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage needs no reset; rd_data is masked while the FIFO is empty.
  always_ff @(posedge main_clk) begin
    if (push) mem[wr_ptr_q] <= avm_m0_readdata;
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Scoreboard bench for avalon_burst_master: expected beats are queued as stimulus is driven
// and popped when the DUT issues an Avalon write or presents a read beat on rd_*.
module tb_avalon_burst_master;

  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 32;
  localparam int BURST_W    = 7;
  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int BE_W       = DATA_W / 8;

  logic                main_clk = 1'b0;
  logic                main_reset_n = 1'b0;
  logic                avm_m0_read;
  logic                avm_m0_write;
  logic [ADDR_W-1:0]   avm_m0_address;
  logic [DATA_W-1:0]   avm_m0_writedata;
  logic [BE_W-1:0]     avm_m0_byteenable;
  logic [BURST_W-1:0]  avm_m0_burstcount;
  logic                avm_m0_waitrequest = 1'b0;
  logic [DATA_W-1:0]   avm_m0_readdata = '0;
  logic                avm_m0_readdatavalid = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_write = 1'b0;
  logic [ADDR_W-1:0]   cmd_address = '0;
  logic [BURST_W-1:0]  cmd_burstcount = '0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                rd_valid;
  logic                rd_ready = 1'b0;
  logic [DATA_W-1:0]   rd_data;
  logic                write_complete;
  logic                read_complete;
  logic                cmd_error;

  always #5 main_clk = ~main_clk;

  avalon_burst_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
    .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .main_clk(main_clk), .main_reset_n(main_reset_n),
    .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
    .avm_m0_address(avm_m0_address), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_burstcount(avm_m0_burstcount),
    .avm_m0_waitrequest(avm_m0_waitrequest), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .write_complete(write_complete), .read_complete(read_complete), .cmd_error(cmd_error)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0]  wr_exp[$];
  logic [DATA_W-1:0]  rd_exp[$];
  logic [ADDR_W-1:0]  exp_addr = '0;
  logic [BURST_W-1:0] exp_burst = '0;
  int wr_beats, rd_pops, rd_req_cycles, rw_seen, wc_pulses, rc_pulses, err_pulses;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge main_clk);
    #1;
  endtask

  task automatic clearCounters();
    wr_beats = 0; rd_pops = 0; rd_req_cycles = 0; rw_seen = 0;
    wc_pulses = 0; rc_pulses = 0; err_pulses = 0;
  endtask

  // Present one command and hold it until the DUT takes it; returns just after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [BURST_W-1:0] cnt);
    bit ok = 0;
    cmd_write = wr; cmd_address = addr; cmd_burstcount = cnt; cmd_valid = 1'b1;
    exp_addr = addr; exp_burst = cnt;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge main_clk);
      if (cmd_ready) ok = 1;
      @(posedge main_clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) checkOutput("cmd_ready_timeout", DATA_W'(cmd_ready), DATA_W'(1));
  endtask

  task automatic writeBeats(input int n, input int gap_after, input int gap_len);
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] d;
      bit ok;
      d = rand128();
      ok = 0;
      wr_data = d; wr_valid = 1'b1;
      wr_exp.push_back(d);
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge main_clk);
        if (wr_ready) ok = 1;
        @(posedge main_clk);
        #1;
      end
      if (!ok) checkOutput("wr_ready_timeout", DATA_W'(wr_ready), DATA_W'(1));
      if (i == gap_after - 1) begin
        wr_valid = 1'b0;
        tick(gap_len);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic readBeats(input int n, input int odd_gap);
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] d;
      d = rand128();
      avm_m0_readdata = d; avm_m0_readdatavalid = 1'b1;
      rd_exp.push_back(d);
      tick(1);
      if ((i % 2 == 1) && odd_gap > 0) begin
        avm_m0_readdatavalid = 1'b0;
        tick(odd_gap);
      end
    end
    avm_m0_readdatavalid = 1'b0;
  endtask

  // Scoreboard side: sampled on the falling edge, before the next accepting rising edge.
  always @(negedge main_clk) begin
    if (main_reset_n) begin
      if (avm_m0_read || avm_m0_write) rw_seen++;
      if (avm_m0_read) rd_req_cycles++;
      if (write_complete) wc_pulses++;
      if (read_complete) rc_pulses++;
      if (cmd_error) err_pulses++;
      if (avm_m0_write && !avm_m0_waitrequest) begin
        wr_beats++;
        checkOutput("wr_addr", DATA_W'(avm_m0_address), DATA_W'(exp_addr));
        checkOutput("wr_burstcount", DATA_W'(avm_m0_burstcount), DATA_W'(exp_burst));
        checkOutput("wr_byteenable", DATA_W'(avm_m0_byteenable), DATA_W'({BE_W{1'b1}}));
        if (wr_exp.size() == 0) checkOutput("wr_unexpected_beat", DATA_W'(avm_m0_write), '0);
        else checkOutput("wr_data", avm_m0_writedata, wr_exp.pop_front());
      end
      if (avm_m0_read && !avm_m0_waitrequest) begin
        checkOutput("rd_addr", DATA_W'(avm_m0_address), DATA_W'(exp_addr));
        checkOutput("rd_burstcount", DATA_W'(avm_m0_burstcount), DATA_W'(exp_burst));
      end
      if (rd_valid && rd_ready) begin
        rd_pops++;
        if (rd_exp.size() == 0) checkOutput("rd_unexpected_beat", DATA_W'(rd_valid), '0);
        else checkOutput("rd_data", rd_data, rd_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearCounters();
    tick(2);
    checkOutput("reset_read", DATA_W'(avm_m0_read), '0);
    checkOutput("reset_write", DATA_W'(avm_m0_write), '0);
    checkOutput("reset_byteenable", DATA_W'(avm_m0_byteenable), '0);
    checkOutput("reset_cmd_ready", DATA_W'(cmd_ready), '0);
    checkOutput("reset_rd_valid", DATA_W'(rd_valid), '0);
    checkOutput("reset_pulses", DATA_W'({write_complete, read_complete, cmd_error}), '0);
    main_reset_n = 1'b1;
    tick(1);
    checkOutput("idle_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));

    $display("[TB] write burst of 4 at 0x100");
    clearCounters();
    applyStimulus(1'b1, 32'h100, 7'd4);
    writeBeats(4, 0, 0);
    checkOutput("cmd_ready_after_write", DATA_W'(cmd_ready), DATA_W'(1));
    tick(2);
    checkOutput("wr_beat_count", DATA_W'(wr_beats), DATA_W'(4));
    checkOutput("wr_complete_pulses", DATA_W'(wc_pulses), DATA_W'(1));
    checkOutput("wr_queue_drained", DATA_W'(wr_exp.size()), '0);

    $display("[TB] read burst of 8 with waitrequest and gapped beats");
    clearCounters();
    rd_ready = 1'b1;
    avm_m0_waitrequest = 1'b1;
    applyStimulus(1'b0, 32'h2000, 7'd8);
    tick(3);
    avm_m0_waitrequest = 1'b0;
    tick(1);
    readBeats(8, 2);
    tick(3);
    checkOutput("rd_request_cycles", DATA_W'(rd_req_cycles), DATA_W'(4));
    checkOutput("rd_pop_count", DATA_W'(rd_pops), DATA_W'(8));
    checkOutput("rd_complete_pulses", DATA_W'(rc_pulses), DATA_W'(1));
    checkOutput("rd_queue_drained", DATA_W'(rd_exp.size()), '0);

    $display("[TB] FIFO reservation with two 16-beat reads held");
    clearCounters();
    rd_ready = 1'b0;
    applyStimulus(1'b0, 32'h4000, 7'd16);
    tick(1);
    readBeats(16, 0);
    tick(2);
    applyStimulus(1'b0, 32'h4400, 7'd16);
    tick(1);
    readBeats(16, 0);
    tick(2);
    cmd_write = 1'b0; cmd_burstcount = 7'd16;
    checkOutput("cmd_ready_fifo_full", DATA_W'(cmd_ready), '0);
    rd_ready = 1'b1;
    tick(15);
    rd_ready = 1'b0;
    checkOutput("cmd_ready_after_15_pops", DATA_W'(cmd_ready), '0);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    checkOutput("cmd_ready_after_16_pops", DATA_W'(cmd_ready), DATA_W'(1));
    applyStimulus(1'b0, 32'h4800, 7'd16);
    tick(1);
    readBeats(16, 0);
    rd_ready = 1'b1;
    tick(40);
    checkOutput("fifo_pop_count", DATA_W'(rd_pops), DATA_W'(48));
    checkOutput("fifo_complete_pulses", DATA_W'(rc_pulses), DATA_W'(3));
    checkOutput("fifo_queue_drained", DATA_W'(rd_exp.size()), '0);

    $display("[TB] illegal burst counts 0 and 17");
    clearCounters();
    applyStimulus(1'b0, 32'h0, 7'd0);
    checkOutput("cmd_error_pulse_high", DATA_W'(cmd_error), DATA_W'(1));
    tick(1);
    checkOutput("cmd_error_pulse_low", DATA_W'(cmd_error), '0);
    applyStimulus(1'b1, 32'h10, 7'd17);
    tick(3);
    checkOutput("cmd_error_pulses", DATA_W'(err_pulses), DATA_W'(2));
    checkOutput("illegal_no_traffic", DATA_W'(rw_seen), '0);

    $display("[TB] write burst of 4 with wr_valid gap after beat 2");
    clearCounters();
    applyStimulus(1'b1, 32'h300, 7'd4);
    writeBeats(4, 2, 5);
    tick(2);
    checkOutput("gap_wr_beat_count", DATA_W'(wr_beats), DATA_W'(4));
    checkOutput("gap_wr_complete", DATA_W'(wc_pulses), DATA_W'(1));
    checkOutput("gap_wr_queue_drained", DATA_W'(wr_exp.size()), '0);

    $display("[TB] reset during a read burst");
    clearCounters();
    rd_ready = 1'b0;
    applyStimulus(1'b0, 32'h500, 7'd8);
    tick(1);
    readBeats(3, 0);
    #2;
    main_reset_n = 1'b0;
    #1;
    checkOutput("midreset_rd_valid", DATA_W'(rd_valid), '0);
    checkOutput("midreset_read", DATA_W'(avm_m0_read), '0);
    checkOutput("midreset_burstcount", DATA_W'(avm_m0_burstcount), '0);
    checkOutput("midreset_address", DATA_W'(avm_m0_address), '0);
    rd_exp.delete();
    tick(1);
    main_reset_n = 1'b1;
    tick(1);
    avm_m0_readdata = rand128();
    avm_m0_readdatavalid = 1'b1;
    tick(2);
    avm_m0_readdatavalid = 1'b0;
    tick(1);
    checkOutput("late_beat_ignored", DATA_W'(rd_valid), '0);
    clearCounters();
    rd_ready = 1'b1;
    applyStimulus(1'b0, 32'h600, 7'd2);
    tick(1);
    readBeats(2, 0);
    tick(3);
    checkOutput("post_reset_pops", DATA_W'(rd_pops), DATA_W'(2));
    checkOutput("post_reset_complete", DATA_W'(rc_pulses), DATA_W'(1));
    checkOutput("post_reset_queue_drained", DATA_W'(rd_exp.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
